pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer for the Lipsi core; successor of the plain PC register.

---
 rtl/pc_sequencer_pkg.sv | 23 ++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_ras.sv | 67 ++++++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lipsi_pc_pkg
// Brief    : PC operation encodings and default widths for the Lipsi PC sequencer
// Revision : 1.0
// ============================================================================
package lipsi_pc_pkg;

    localparam int PC_W_DEF = 8;
    localparam logic [PC_W_DEF-1:0] RESET_VEC_DEF = '0;

    // Codes 6 and 7 are reserved and decode as HOLD.
    typedef enum logic [2:0] {
        PC_OP_HOLD = 3'd0,
        PC_OP_INC  = 3'd1,
        PC_OP_JUMP = 3'd2,
        PC_OP_BREL = 3'd3,
        PC_OP_CALL = 3'd4,
        PC_OP_RET  = 3'd5
    } pc_op_e;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Control-side bundle between decoder/FSM and the PC sequencer
// Revision : 1.0
// ============================================================================
interface pc_sequencer_if
    import lipsi_pc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic            pc_en;
    logic [2:0]      pc_op;
    logic [PC_W-1:0] pc_in;
    logic [PC_W-1:0] pc_out;
    logic [PC_W-1:0] pc_next;
    logic            ras_full;
    logic            ras_empty;
    logic            ras_err;

    modport master (
        output pc_en, pc_op, pc_in,
        input  pc_out, pc_next, ras_full, ras_empty, ras_err
    );

    modport slave (
        input  pc_en, pc_op, pc_in,
        output pc_out, pc_next, ras_full, ras_empty, ras_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module   : pc_ras
// Brief    : Parametrised return-address LIFO with registered full/empty flags
// Revision : 1.0
// ============================================================================
module pc_ras #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire logic [W-1:0] push_data,
    output logic      [W-1:0] top,
    output logic              full,
    output logic              empty
);
    localparam int c_ptr_w = $clog2(DEPTH + 1);
    localparam int c_idx_w = $clog2(DEPTH);

    logic [c_ptr_w-1:0] ptr_q, ptr_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [W-1:0]       mem_q [DEPTH];
    logic [c_idx_w-1:0] wr_idx;
    logic [c_idx_w-1:0] rd_idx;

    assign wr_idx = c_idx_w'(ptr_q);
    assign rd_idx = c_idx_w'(ptr_q - c_ptr_w'(1));

    always_comb begin
        ptr_d = ptr_q;
        if (push && !full_q) begin
            ptr_d = ptr_q + c_ptr_w'(1);
        end else if (pop && !empty_q) begin
            ptr_d = ptr_q - c_ptr_w'(1);
        end
        full_d  = (ptr_d == c_ptr_w'(DEPTH));
        empty_d = (ptr_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Contents need no reset: the pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !full_q) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign top   = empty_q ? '0 : mem_q[rd_idx];
    assign full  = full_q;
    assign empty = empty_q;
endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Lipsi program-counter sequencer (hold/inc/jump/branch, optional
//            call/return stack enabled by macro PC_RAS_EN)
// Revision : 1.0
// ============================================================================
module pc_sequencer
    import lipsi_pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter int              RAS_DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    pc_sequencer_if.slave bus
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_q + PC_W'(1);

`ifdef PC_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_full;
    logic            ras_empty;
    logic            err_q, err_d;

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.ras_full  = ras_full;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_err   = err_q;
`else
    assign bus.ras_full  = 1'b0;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_err   = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
`ifdef PC_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        err_d    = err_q;
`endif
        if (bus.pc_en) begin
            case (bus.pc_op)
                PC_OP_INC:  pc_d = pc_inc;
                PC_OP_JUMP: pc_d = bus.pc_in;
                // Same-width add is the sign-extended add modulo 2**PC_W.
                PC_OP_BREL: pc_d = pc_q + bus.pc_in;
`ifdef PC_RAS_EN
                PC_OP_CALL: begin
                    if (ras_full) begin
                        err_d = 1'b1;
                    end else begin
                        ras_push = 1'b1;
                        pc_d     = bus.pc_in;
                    end
                end
                PC_OP_RET: begin
                    if (ras_empty) begin
                        err_d = 1'b1;
                    end else begin
                        ras_pop = 1'b1;
                        pc_d    = ras_top;
                    end
                end
`else
                PC_OP_CALL: pc_d = bus.pc_in;
`endif
                default:    pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc_out  = pc_q;
    assign bus.pc_next = pc_d;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Self-checking bench for pc_sequencer against a queue-based model
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;
    localparam int          DEPTH = 4;
    localparam logic [7:0]  RV    = 8'h10;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pc_sequencer_if #(.PC_W(8)) bus ();

    pc_sequencer #(
        .PC_W      (8),
        .RESET_VEC (RV),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_pc = RV;
    logic [7:0] m_stack [$];
    bit         m_err = 1'b0;
    logic [7:0] exp_next, obs_next;
    logic [2:0] exp_flags;

    function automatic logic [2:0] model_flags();
        int n = m_stack.size();
        return {RAS_ON && (n == DEPTH), !RAS_ON || (n == 0), RAS_ON && m_err};
    endfunction

    // Apply one cycle of stimulus and advance the model; checks live in tests.
    task automatic step(input bit r, input bit en, input logic [2:0] op, input logic [7:0] din);
        @(negedge clk);
        reset = r;
        bus.pc_en = en;
        bus.pc_op = op;
        bus.pc_in = din;
        #1;
        obs_next = bus.pc_next;
        exp_next = m_pc;
        if (en) begin
            case (op)
                3'd1: exp_next = m_pc + 8'd1;
                3'd2: exp_next = din;
                3'd3: exp_next = 8'(int'(m_pc) + int'($signed(din)));
                3'd4: begin
                    if (!RAS_ON) exp_next = din;
                    else if (m_stack.size() == DEPTH) m_err = 1'b1;
                    else begin
                        m_stack.push_back(m_pc + 8'd1);
                        exp_next = din;
                    end
                end
                3'd5: begin
                    if (RAS_ON) begin
                        if (m_stack.size() == 0) m_err = 1'b1;
                        else exp_next = m_stack.pop_back();
                    end
                end
                default: exp_next = m_pc;
            endcase
        end
        if (r) begin
            m_pc = RV;
            m_stack.delete();
            m_err = 1'b0;
        end else begin
            m_pc = exp_next;
        end
        exp_flags = model_flags();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 3'd0, 8'h00);
        step(1, 1, 3'd1, 8'h00);
        checks++;
        if (bus.pc_out !== 8'h10) begin
            failures++;
            $display("FAIL reset.pc_out got=%h exp=%h", bus.pc_out, 8'h10);
        end
        checks++;
        if ({bus.ras_full, bus.ras_empty, bus.ras_err} !== 3'b010) begin
            failures++;
            $display("FAIL reset.flags got=%b exp=%b", {bus.ras_full, bus.ras_empty, bus.ras_err}, 3'b010);
        end
    endtask

    task automatic test_inc();
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 3'd1, 8'($urandom));
            checks++;
            if (bus.pc_out !== 8'(8'h10 + i)) begin
                failures++;
                $display("FAIL inc.pc_out[%0d] got=%h exp=%h", i, bus.pc_out, 8'(8'h10 + i));
            end
            checks++;
            if (obs_next !== exp_next) begin
                failures++;
                $display("FAIL inc.pc_next[%0d] got=%h exp=%h", i, obs_next, exp_next);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 3'($urandom_range(0, 7)), 8'($urandom));
            checks++;
            if (bus.pc_out !== 8'h13 || obs_next !== 8'h13) begin
                failures++;
                $display("FAIL hold_en.pc got=%h/%h exp=13/13", bus.pc_out, obs_next);
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] ops [5] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd3};
        logic [7:0] ins [5] = '{8'hFF, 8'h00, 8'h02, 8'hFC, 8'h05};
        logic [7:0] want[5] = '{8'hFF, 8'h00, 8'h02, 8'hFE, 8'h03};
        for (int i = 0; i < 5; i++) begin
            step(0, 1, ops[i], ins[i]);
            checks++;
            if (bus.pc_out !== want[i]) begin
                failures++;
                $display("FAIL wrap.pc_out[%0d] got=%h exp=%h", i, bus.pc_out, want[i]);
            end
            checks++;
            if (obs_next !== want[i]) begin
                failures++;
                $display("FAIL wrap.pc_next[%0d] got=%h exp=%h", i, obs_next, want[i]);
            end
        end
    endtask

    task automatic test_call_ret();
        logic [2:0] ops [5] = '{3'd2, 3'd4, 3'd4, 3'd5, 3'd5};
        logic [7:0] ins [5] = '{8'h20, 8'h40, 8'h60, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            step(0, 1, ops[i], ins[i]);
            checks++;
            if (bus.pc_out !== m_pc || obs_next !== exp_next) begin
                failures++;
                $display("FAIL call_ret.pc[%0d] got=%h/%h exp=%h/%h", i, bus.pc_out, obs_next, m_pc, exp_next);
            end
            checks++;
            if ({bus.ras_full, bus.ras_empty, bus.ras_err} !== exp_flags) begin
                failures++;
                $display("FAIL call_ret.flags[%0d] got=%b exp=%b", i, {bus.ras_full, bus.ras_empty, bus.ras_err}, exp_flags);
            end
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 3'd0, 8'h00);
        step(0, 1, 3'd2, 8'h20);
        for (int i = 0; i < 8; i++) begin
            // Five calls, then return, then two increments: error must stay sticky
            step(0, 1, (i < 5) ? 3'd4 : ((i == 5) ? 3'd5 : 3'd1), 8'($urandom));
            checks++;
            if (bus.pc_out !== m_pc || obs_next !== exp_next) begin
                failures++;
                $display("FAIL overflow.pc[%0d] got=%h/%h exp=%h/%h", i, bus.pc_out, obs_next, m_pc, exp_next);
            end
            checks++;
            if ({bus.ras_full, bus.ras_empty, bus.ras_err} !== exp_flags) begin
                failures++;
                $display("FAIL overflow.flags[%0d] got=%b exp=%b", i, {bus.ras_full, bus.ras_empty, bus.ras_err}, exp_flags);
            end
        end
    endtask

    task automatic test_underflow();
        step(1, 0, 3'd0, 8'h00);
        step(0, 1, 3'd2, 8'h33);
        step(0, 1, 3'd5, 8'h77);
        checks++;
        if (bus.pc_out !== 8'h33 || obs_next !== 8'h33) begin
            failures++;
            $display("FAIL underflow.pc got=%h/%h exp=33/33", bus.pc_out, obs_next);
        end
        checks++;
        if ({bus.ras_full, bus.ras_empty, bus.ras_err} !== exp_flags) begin
            failures++;
            $display("FAIL underflow.flags got=%b exp=%b", {bus.ras_full, bus.ras_empty, bus.ras_err}, exp_flags);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 3'd2, 8'h20);
        step(0, 1, 3'd4, 8'h40);
        step(0, 1, 3'd4, 8'h60);
        step(1, 1, 3'd4, 8'h80);
        checks++;
        if (bus.pc_out !== RV || {bus.ras_full, bus.ras_empty, bus.ras_err} !== 3'b010) begin
            failures++;
            $display("FAIL reset_mid got=%h/%b exp=%h/010", bus.pc_out, {bus.ras_full, bus.ras_empty, bus.ras_err}, RV);
        end
        step(0, 1, 3'd5, 8'h00);
        checks++;
        if (bus.pc_out !== m_pc || {bus.ras_full, bus.ras_empty, bus.ras_err} !== exp_flags) begin
            failures++;
            $display("FAIL reset_mid.ret got=%h/%b exp=%h/%b", bus.pc_out, {bus.ras_full, bus.ras_empty, bus.ras_err}, m_pc, exp_flags);
        end
    endtask

    task automatic test_random();
        bit r;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            step(r, $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), 8'($urandom));
            checks++;
            if (bus.pc_out !== m_pc) begin
                failures++;
                $display("FAIL random.pc_out[%0d] got=%h exp=%h", i, bus.pc_out, m_pc);
            end
            checks++;
            if (!r && obs_next !== exp_next) begin
                failures++;
                $display("FAIL random.pc_next[%0d] got=%h exp=%h", i, obs_next, exp_next);
            end
            checks++;
            if ({bus.ras_full, bus.ras_empty, bus.ras_err} !== exp_flags) begin
                failures++;
                $display("FAIL random.flags[%0d] got=%b exp=%b", i, {bus.ras_full, bus.ras_empty, bus.ras_err}, exp_flags);
            end
        end
    endtask

    initial begin
        bus.pc_en = 1'b0;
        bus.pc_op = 3'd0;
        bus.pc_in = 8'h00;
        test_reset();
        test_inc();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
